// File: rtl/edge_event_logger_pkg.sv
// Shared definitions for the edge event logger: default sizes, the record
// layout at default widths, and the FIFO pointer-width helper.
package edge_event_logger_pkg;

    localparam int unsigned DEF_DATA_W = 2;
    localparam int unsigned DEF_TS_W   = 16;
    localparam int unsigned DEF_DEPTH  = 8;
    localparam int unsigned DEF_CNT_W  = 8;

    // One logged transition at the default widths: new bus value plus the
    // cycle it was sampled in.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_TS_W-1:0]   ts;
    } record_t;

    // Address bits needed to index a DEPTH-entry buffer; never less than 1.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/edge_event_logger_sync_fifo.sv
// First-word-fallthrough synchronous FIFO with wrap-bit pointers.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, wdata     write request and data; taken when not full, or when full
//                   and a pop happens in the same cycle
//   pop             read request; ignored while empty
//   rdata           head entry, zero while empty
//   full, empty     occupancy flags derived from the registered pointers
module sync_fifo
    import edge_event_logger_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_DATA_W + DEF_TS_W,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage is never reset; empty gates what is visible at rdata.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/edge_event_logger.sv
// Timestamps every change of a narrow bus against a free-running cycle
// counter and queues (value, timestamp) records for a valid/ready consumer.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   in_data      monitored bus, sampled every cycle
//   clear        pulse: clears overflow and drop_count
//   ev_valid     head record available (registered, independent of ev_ready)
//   ev_ready     consumer accepts the head record when ev_valid is high
//   ev_data      head record value
//   ev_time      head record timestamp
//   overflow     sticky flag: a record has been dropped since reset/clear
//   drop_count   saturating count of dropped records
module edge_event_logger
    import edge_event_logger_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned TS_W   = DEF_TS_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [DATA_W-1:0] ev_data,
    output logic [TS_W-1:0]   ev_time,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_count
);

    // Record layout at this instance's widths.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TS_W-1:0]   ts;
    } rec_t;

    logic [TS_W-1:0]   tstamp;
    logic [DATA_W-1:0] prev;
    logic              armed;
    logic              change;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    rec_t              wr_rec;
    rec_t              head;

    // The first sample after reset only primes prev; it is never an event.
    assign change = armed && (in_data != prev);
    assign pop    = ev_valid && ev_ready;
    assign drop   = change && fifo_full && !pop;

    assign wr_rec.data = in_data;
    assign wr_rec.ts   = tstamp;

    sync_fifo #(
        .WIDTH ($bits(rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (change),
        .wdata (wr_rec),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ev_valid = !fifo_empty;
    assign ev_data  = head.data;
    assign ev_time  = head.ts;

    // Timestamp counter and change detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            tstamp <= '0;
            prev   <= '0;
            armed  <= 1'b0;
        end else begin
            tstamp <= tstamp + TS_W'(1);
            prev   <= in_data;
            armed  <= 1'b1;
        end
    end

    // Drop accounting; a drop coinciding with clear counts as the first after clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear) begin
                drop_count <= CNT_W'(1);
            end else if (drop_count != {CNT_W{1'b1}}) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end else if (clear) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule
